// File: rtl/insn_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : insn_queue_pkg
// Description : Shared decode types and the instruction-queue entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package insn_queue_pkg;

    localparam int c_xlen = 64;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } e_instruction_format;

    typedef enum logic [2:0] {
        FU_ALU = 3'd0,
        FU_MUL = 3'd1,
        FU_DIV = 3'd2,
        FU_LSU = 3'd3,
        FU_BRU = 3'd4
    } e_functional_unit;

    typedef struct packed {
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        e_instruction_format insn_fmt;
        e_functional_unit    station;
        logic [c_xlen-1:0]   imm;
        logic [c_xlen-1:0]   pc;
    } t_queue_entry;

endpackage
`default_nettype wire

// File: rtl/queue_window_mux.sv
`default_nettype none
// ============================================================================
// Module      : queue_window_mux
// Description : Maps a circular array plus head pointer onto ordered slots.
// Revision    : 1.0 - initial release
// ============================================================================
module queue_window_mux
    import insn_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SLOTS = 3
) (
    input  t_queue_entry               entries_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head_i,
    output t_queue_entry               slots_o   [SLOTS]
);

    localparam int c_ptr_w = $clog2(DEPTH);

    // Pointer arithmetic truncates to c_ptr_w bits, so indices wrap modulo DEPTH.
    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
        logic [c_ptr_w-1:0] w_idx;
        assign w_idx      = head_i + c_ptr_w'(k);
        assign slots_o[k] = entries_i[w_idx];
    end

endmodule
`default_nettype wire

// File: rtl/insn_queue.sv
`default_nettype none
// ============================================================================
// Module      : insn_queue
// Description : Circular decoded-instruction buffer feeding an in-order issue window.
// Revision    : 1.0 - initial release
// ============================================================================
module insn_queue
    import insn_queue_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int DATA_WIDTH  = 64,
    parameter int MULTI_ISSUE = 3
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         flush_i,
    input  logic                                         push_valid_i,
    output logic                                         push_ready_o,
    input  logic [4:0]                                   push_rd_i,
    input  logic [4:0]                                   push_rs1_i,
    input  logic [4:0]                                   push_rs2_i,
    input  e_instruction_format                          push_insn_fmt_i,
    input  e_functional_unit                             push_station_i,
    input  logic [DATA_WIDTH-1:0]                        push_imm_i,
    input  logic [DATA_WIDTH-1:0]                        push_pc_i,
    input  logic [$clog2(MULTI_ISSUE):0]                 issue_cnt_i,
    output logic [$clog2(MULTI_ISSUE):0]                 queue_rdy_cnt_o,
    output logic [MULTI_ISSUE-1:0][4:0]                  queue_rd_o,
    output logic [MULTI_ISSUE-1:0][4:0]                  queue_rs1_o,
    output logic [MULTI_ISSUE-1:0][4:0]                  queue_rs2_o,
    output e_instruction_format [MULTI_ISSUE-1:0]        queue_insn_fmt_o,
    output e_functional_unit [MULTI_ISSUE-1:0]           queue_stations_o,
    output logic [MULTI_ISSUE-1:0][DATA_WIDTH-1:0]       queue_imm_o,
    output logic [MULTI_ISSUE-1:0][DATA_WIDTH-1:0]       queue_pc_o,
    output logic [$clog2(DEPTH):0]                       count_o
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;
    localparam int c_rdy_w = $clog2(MULTI_ISSUE) + 1;

    if (DEPTH < MULTI_ISSUE || (DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2) begin : g_bad_depth
        $error("insn_queue: DEPTH must be a power of two >= MULTI_ISSUE");
    end
    if (DATA_WIDTH != c_xlen) begin : g_bad_width
        $error("insn_queue: DATA_WIDTH must equal the entry payload width");
    end

    t_queue_entry         r_entries [DEPTH];
    logic [c_ptr_w-1:0]   r_head;
    logic [c_ptr_w-1:0]   r_tail;
    logic [c_cnt_w-1:0]   r_count;

    logic                 w_push_fire;
    logic [c_rdy_w-1:0]   w_rdy_cnt;
    logic [c_rdy_w-1:0]   w_pop_amt;
    t_queue_entry         w_push_entry;
    t_queue_entry         w_window [MULTI_ISSUE];

    // Everything below depends only on registered state; the arbiter closes a loop on it.
    assign push_ready_o    = (r_count != c_cnt_w'(DEPTH));
    assign w_rdy_cnt       = (r_count >= c_cnt_w'(MULTI_ISSUE)) ? c_rdy_w'(MULTI_ISSUE)
                                                                : c_rdy_w'(r_count);
    assign queue_rdy_cnt_o = w_rdy_cnt;
    assign count_o         = r_count;

    assign w_push_fire = push_valid_i && push_ready_o;
    assign w_pop_amt   = (issue_cnt_i > w_rdy_cnt) ? w_rdy_cnt : issue_cnt_i;

    assign w_push_entry = '{
        rd:       push_rd_i,
        rs1:      push_rs1_i,
        rs2:      push_rs2_i,
        insn_fmt: push_insn_fmt_i,
        station:  push_station_i,
        imm:      push_imm_i,
        pc:       push_pc_i
    };

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + c_ptr_w'(w_pop_amt);
            r_count <= r_count + c_cnt_w'(w_push_fire) - c_cnt_w'(w_pop_amt);
            if (w_push_fire) begin
                r_tail <= r_tail + 1'b1;
            end
        end
    end

    // Payload storage carries no reset; slots beyond the ready count are don't-care.
    always_ff @(posedge clk) begin
        if (w_push_fire && !flush_i) begin
            r_entries[r_tail] <= w_push_entry;
        end
    end

    queue_window_mux #(
        .DEPTH (DEPTH),
        .SLOTS (MULTI_ISSUE)
    ) u_window_mux (
        .entries_i (r_entries),
        .head_i    (r_head),
        .slots_o   (w_window)
    );

    for (genvar k = 0; k < MULTI_ISSUE; k++) begin : g_out
        assign queue_rd_o[k]       = w_window[k].rd;
        assign queue_rs1_o[k]      = w_window[k].rs1;
        assign queue_rs2_o[k]      = w_window[k].rs2;
        assign queue_insn_fmt_o[k] = w_window[k].insn_fmt;
        assign queue_stations_o[k] = w_window[k].station;
        assign queue_imm_o[k]      = w_window[k].imm;
        assign queue_pc_o[k]       = w_window[k].pc;
    end

`ifndef SYNTHESIS
    a_issue_le_ready : assert property (@(posedge clk) disable iff (!rst)
        issue_cnt_i <= queue_rdy_cnt_o)
        else $error("insn_queue: issue_cnt_i exceeds queue_rdy_cnt_o");
`endif

endmodule
`default_nettype wire
